// File: rtl/cameralink_frame_capture.sv
// Multi-tap CameraLink capture back end: qualifies pixels, checks geometry, buffers beats into a FWFT FIFO.
// Optional CAMLINK_CAPTURE_STATS_EN adds frame_total / drop_total statistics outputs.
module cameralink_frame_capture #(
  parameter int TAPS        = 3,
  parameter int PIXEL_WIDTH = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int EXP_PIXELS  = 0,
  parameter int EXP_LINES   = 0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        FVV,
  input  logic                        LVV,
  input  logic                        VCE,
  input  logic [TAPS*PIXEL_WIDTH-1:0] pix_data,
  output logic [TAPS*PIXEL_WIDTH-1:0] out_data,
  output logic                        out_sof,
  output logic                        out_eol,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        frame_done,
  output logic [15:0]                 line_count,
  output logic [15:0]                 pixel_count,
  output logic                        err_overflow,
  output logic                        err_geometry,
  input  logic                        err_clear,
`ifdef CAMLINK_CAPTURE_STATS_EN
  output logic [31:0]                 frame_total,
  output logic [31:0]                 drop_total,
`endif
  output logic [1:0]                  o_dbg_state
);

  localparam int DW = TAPS * PIXEL_WIDTH;
  localparam int EW = DW + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] EXP_P = 16'(EXP_PIXELS);
  localparam logic [15:0] EXP_L = 16'(EXP_LINES);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    IN_FRAME   = 2'd1,
    DROP       = 2'd2
  } state_t;

  // Output handshake: a beat transfers on any rising edge where out_valid & out_ready;
  // out_data/out_sof/out_eol are stable while out_valid is high and out_ready is low.

  state_t        r_state;
  state_t        w_next;
  logic          r_fvv_prev;
  logic          r_hold_valid;
  logic          r_hold_sof;
  logic [DW-1:0] r_hold_data;
  logic          r_sof_pend;
  logic [15:0]   r_beat_cnt;
  logic [15:0]   r_line_cnt;
  logic [15:0]   r_line_count;
  logic [15:0]   r_pixel_count;
  logic          r_frame_done;
  logic          r_err_ovf;
  logic          r_err_geom;
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [EW-1:0] r_mem [FIFO_DEPTH];

  logic          w_in_frame;
  logic          w_beat;
  logic          w_frame_start;
  logic          w_capture;
  logic          w_count;
  logic          w_frame_end;
  logic          w_line_close;
  logic          w_push;
  logic          w_push_eol;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_overflow;
  logic          w_write;
  logic          w_geom_err;
  logic [15:0]   w_beat_inc;
  logic [15:0]   w_line_next;
  logic [EW-1:0] w_rd;

  assign w_in_frame    = (r_state != WAIT_FRAME);
  assign w_beat        = FVV & LVV & VCE;
  // r_fvv_prev resets high so FVV already high out of reset is not taken as a rising edge.
  assign w_frame_start = (r_state == WAIT_FRAME) & FVV & ~r_fvv_prev & enable;
  assign w_capture     = w_beat & ((r_state == IN_FRAME) | w_frame_start);
  assign w_count       = w_beat & (w_in_frame | w_frame_start);
  assign w_frame_end   = w_in_frame & ~FVV;
  assign w_line_close  = w_in_frame & ~(FVV & LVV) & (r_beat_cnt != 16'd0);

  // The hold stage only holds a beat while IN_FRAME; the next beat or end of line/frame releases it.
  assign w_push      = r_hold_valid & (w_capture | ~(FVV & LVV));
  assign w_push_eol  = ~w_capture;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop      = ~w_empty & out_ready;
  assign w_overflow = w_push & w_full & ~w_pop;
  assign w_write    = w_push & ~w_overflow;

  assign w_beat_inc  = (r_beat_cnt == 16'hFFFF) ? r_beat_cnt : r_beat_cnt + 16'd1;
  assign w_line_next = (w_line_close && (r_line_cnt != 16'hFFFF)) ? r_line_cnt + 16'd1 : r_line_cnt;
  assign w_geom_err  = ((EXP_PIXELS != 0) && w_line_close && (r_beat_cnt != EXP_P)) ||
                       ((EXP_LINES != 0) && w_frame_end && (w_line_next != EXP_L));

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_FRAME: if (w_frame_start) w_next = IN_FRAME;
      IN_FRAME: begin
        if (!FVV)            w_next = WAIT_FRAME;
        else if (w_overflow) w_next = DROP;
      end
      DROP:       if (!FVV) w_next = WAIT_FRAME;
      default:    w_next = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= WAIT_FRAME;
      r_fvv_prev <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_fvv_prev <= FVV;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_valid <= 1'b0;
      r_hold_sof   <= 1'b0;
      r_hold_data  <= '0;
      r_sof_pend   <= 1'b0;
    end else begin
      if (w_overflow) begin
        r_hold_valid <= 1'b0;
      end else if (w_capture) begin
        r_hold_valid <= 1'b1;
        r_hold_sof   <= w_frame_start | r_sof_pend;
        r_hold_data  <= pix_data;
      end else if (w_push) begin
        r_hold_valid <= 1'b0;
      end
      if (w_capture || w_frame_end) r_sof_pend <= 1'b0;
      else if (w_frame_start)       r_sof_pend <= 1'b1;
    end
  end

  // Geometry is measured for every accepted frame, including frames that fell into DROP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_cnt    <= '0;
      r_line_cnt    <= '0;
      r_line_count  <= '0;
      r_pixel_count <= '0;
      r_frame_done  <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_err_geom    <= 1'b0;
    end else begin
      if (w_line_close) begin
        r_beat_cnt    <= '0;
        r_pixel_count <= r_beat_cnt;
      end else if (w_count) begin
        r_beat_cnt <= w_beat_inc;
      end
      if (w_frame_end) begin
        r_line_cnt   <= '0;
        r_line_count <= w_line_next;
      end else begin
        r_line_cnt <= w_line_next;
      end
      r_frame_done <= w_frame_end;
      r_err_ovf    <= (r_err_ovf & ~err_clear) | w_overflow;
      r_err_geom   <= (r_err_geom & ~err_clear) | w_geom_err;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_write) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)   r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: empty pointers mask whatever it holds.
  always_ff @(posedge clock) begin
    if (w_write) r_mem[r_wptr[AW-1:0]] <= {r_hold_sof, w_push_eol, r_hold_data};
  end

  assign w_rd         = r_mem[r_rptr[AW-1:0]];
  assign out_valid    = ~w_empty;
  assign out_data     = w_empty ? '0 : w_rd[DW-1:0];
  assign out_eol      = ~w_empty & w_rd[DW];
  assign out_sof      = ~w_empty & w_rd[DW+1];
  assign frame_done   = r_frame_done;
  assign line_count   = r_line_count;
  assign pixel_count  = r_pixel_count;
  assign err_overflow = r_err_ovf;
  assign err_geometry = r_err_geom;
  assign o_dbg_state  = r_state;

`ifdef CAMLINK_CAPTURE_STATS_EN
  logic [31:0] r_frame_total;
  logic [31:0] r_drop_total;
  logic [1:0]  w_drop_n;

  // An overflow loses the held beat, plus the incoming beat if one arrived that cycle.
  assign w_drop_n = {1'b0, w_overflow} + {1'b0, w_overflow & w_capture} +
                    {1'b0, (r_state == DROP) & w_beat};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_total <= '0;
      r_drop_total  <= '0;
    end else begin
      if (w_frame_end) r_frame_total <= r_frame_total + 32'd1;
      if (r_drop_total > (32'hFFFF_FFFF - 32'(w_drop_n))) r_drop_total <= 32'hFFFF_FFFF;
      else                                                  r_drop_total <= r_drop_total + 32'(w_drop_n);
    end
  end

  assign frame_total = r_frame_total;
  assign drop_total  = r_drop_total;
`endif

endmodule
